hex_display_arbiter: RTL and testbench



---
 rtl/hex_display_arbiter_if.sv | 31 +++
 rtl/hex_display_arbiter.sv | 151 +++++++++++++++
 tb/tb_hex_display_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_display_arbiter_if.sv
// Request/ack and Avalon-MM bus bundle between requesters, hex_display_arbiter and the PIO.
// Carries no state of its own, so it adds no latency.
// Requesters hold req until ack. The PIO write side has no backpressure.
interface hex_display_arbiter_if;
    logic        req0;
    logic        req1;
    logic [15:0] data0;
    logic [15:0] data1;
    logic        ack0;
    logic        ack1;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [15:0] shown;
    logic        busy;

    // Requester / observer side
    modport master (
        output req0, req1, data0, data1,
        input  ack0, ack1, avm_address, avm_chipselect, avm_write_n,
        input  avm_writedata, shown, busy
    );

    // Arbiter side
    modport slave (
        input  req0, req1, data0, data1,
        output ack0, ack1, avm_address, avm_chipselect, avm_write_n,
        output avm_writedata, shown, busy
    );
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter for two requesters sharing the HEX5/HEX4 PIO. It blanks the display after reset.
// Latency: a req sampled in IDLE gives WRITE and ack one cycle later. Grants are spaced at least HOLD_CYCLES+1 cycles apart.
// Backpressure: requests are ignored outside IDLE and stay pending. HEXARB_ENCODE_EN selects the hex-digit segment encoding.
module hex_display_arbiter #(
    parameter int HOLD_CYCLES = 4
) (
    input logic                  clk,
    input logic                  reset_n,
    hex_display_arbiter_if.slave bus
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_WRITE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        last_q;     // most recent grantee: 0 or 1
    logic [1:0]  gnt_q;      // one-hot grantee of the pending WRITE; 0 marks the blanking write
    logic [15:0] pat_q;      // pattern to be written in WRITE
    logic [15:0] shown_q;    // shadow of the PIO data register
    logic [31:0] wd_q;       // last value placed on the write bus
    logic [CW-1:0] cnt_q;    // dwell counter

    logic        any_req;
    logic        pick1;
    logic [15:0] sel_data;
    logic [15:0] pat_next;
    logic        do_write;
    logic        hold_done;

`ifdef HEXARB_ENCODE_EN
    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Only the low byte carries digits. The high byte is deliberately discarded.
    logic unused_hi_byte;
    assign unused_hi_byte = ^sel_data[15:8];
`endif

    // Round-robin choice and pattern formation for a grant taken in IDLE
    always_comb begin
        any_req  = bus.req0 | bus.req1;
        // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
        pick1    = bus.req1 & (~bus.req0 | ~last_q);
        sel_data = pick1 ? bus.data1 : bus.data0;
`ifdef HEXARB_ENCODE_EN
        pat_next = {1'b0, seg7(sel_data[7:4]), 1'b0, seg7(sel_data[3:0])};
`else
        pat_next = sel_data;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, bus strobes and acks
    always_comb begin
        state_d            = state_q;
        // The blanking write always goes out. A user write is skipped when it would not change the display.
        do_write           = (state_q == S_WRITE) && ((gnt_q == 2'b00) || (pat_q != shown_q));
        // Leave HOLD once the decremented count is at or below 1. This also gives one HOLD cycle when HOLD_CYCLES is 1.
        hold_done          = ({1'b0, cnt_q} <= (CW + 1)'(2));
        bus.ack0           = (state_q == S_WRITE) && gnt_q[0];
        bus.ack1           = (state_q == S_WRITE) && gnt_q[1];
        bus.avm_address    = 2'd0;
        bus.avm_chipselect = do_write;
        bus.avm_write_n    = ~do_write;
        bus.avm_writedata  = do_write ? {16'h0000, pat_q} : wd_q;
        bus.shown          = shown_q;
        bus.busy           = (state_q != S_IDLE);

        case (state_q)
            S_INIT:  state_d = S_WRITE;
            S_IDLE:  if (any_req) state_d = S_WRITE;
            S_WRITE: state_d = S_HOLD;
            S_HOLD:  if (hold_done) state_d = S_IDLE;
            default: state_d = S_INIT;
        endcase
    end

    // Datapath: grant bookkeeping, pattern latch, shadow and dwell counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
            pat_q   <= 16'h0000;
            shown_q <= 16'h0000;
            wd_q    <= 32'h0000_0000;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    pat_q <= 16'h7F7F;
                    gnt_q <= 2'b00;
                end
                S_IDLE: begin
                    if (any_req) begin
                        gnt_q  <= pick1 ? 2'b10 : 2'b01;
                        last_q <= pick1;
                        pat_q  <= pat_next;
                    end
                end
                S_WRITE: begin
                    if (do_write) begin
                        shown_q <= pat_q;
                        wd_q    <= {16'h0000, pat_q};
                    end
                    cnt_q <= CW'(HOLD_CYCLES);
                end
                default: begin
                    cnt_q <= cnt_q - CW'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter: directed scenarios plus a randomized run against a grant-level model.
// Outputs are sampled 1 time unit after the rising edge, and inputs are driven on the falling edge.
// Every wait on the DUT is bounded.
module tb_hex_display_arbiter;

    localparam int H        = 4;
    localparam int HOLD_LEN = (H > 1) ? H - 1 : 1;   // HOLD cycles per grant
    localparam int PERIOD   = HOLD_LEN + 2;          // WRITE + HOLD + IDLE

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    hex_display_arbiter_if bus();

    hex_display_arbiter #(.HOLD_CYCLES(H)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_last;
    logic [15:0] m_shown;
    bit          pend [2];
    logic [15:0] pdat [2];
    logic [15:0] last_data;

`ifdef HEXARB_ENCODE_EN
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`endif

    function automatic logic [15:0] exp_pat(input logic [15:0] d);
`ifdef HEXARB_ENCODE_EN
        return {1'b0, seg_tab[d[7:4]], 1'b0, seg_tab[d[3:0]]};
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (bus.busy === 1'b0) break;
            tick();
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle: busy=%b required 0 within 40 cycles", bus.busy);
        end
    endtask

    task automatic test_reset();
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.data0 = 16'h0; bus.data1 = 16'h0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_write_n, bus.avm_address,
             bus.avm_writedata, bus.shown, bus.busy} !== {4'b0001, 2'd0, 32'h0, 16'h0, 1'b1}) begin
            bad++;
            $display("FAIL reset_values: ack=%b%b cs=%b wn=%b addr=%0d wd=%h shown=%h busy=%b",
                     bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_write_n, bus.avm_address,
                     bus.avm_writedata, bus.shown, bus.busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
        m_last = 1; m_shown = 16'h0000;
        tick();
        total++;
        if ({bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata, bus.busy}
            !== {4'b0010, 32'h0000_7F7F, 1'b1}) begin
            bad++;
            $display("FAIL init_write: ack=%b%b cs=%b wn=%b wd=%h busy=%b required cs=1 wn=0 wd=00007f7f",
                     bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata, bus.busy);
        end
        m_shown = 16'h7F7F;
        tick();
        total++;
        if ({bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata, bus.shown}
            !== {2'b01, 32'h0000_7F7F, 16'h7F7F}) begin
            bad++;
            $display("FAIL init_after: cs=%b wn=%b wd=%h shown=%h required cs=0 wn=1 wd=00007f7f shown=7f7f",
                     bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata, bus.shown);
        end
        for (int k = 3; k <= HOLD_LEN + 1; k++) begin
            tick();
            total++;
            if (bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL init_busy_hold: edge %0d busy=%b required 1", k, bus.busy);
            end
        end
        tick();
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL init_busy_drop: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_single_grant();
        logic [15:0] e;
        e = exp_pat(16'h00A5);
        @(negedge clk);
        bus.req0 = 1'b1; bus.data0 = 16'h00A5;
        tick();
        total++;
        if ({bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata}
            !== {4'b1010, 16'h0, e}) begin
            bad++;
            $display("FAIL single_write: ack=%b%b cs=%b wn=%b wd=%h required ack=10 cs=1 wn=0 wd=%h",
                     bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata, {16'h0, e});
        end
        @(negedge clk);
        bus.req0 = 1'b0;
        tick();
        total++;
        if ({bus.ack0, bus.shown} !== {1'b0, e}) begin
            bad++;
            $display("FAIL single_after: ack0=%b shown=%h required ack0=0 shown=%h", bus.ack0, bus.shown, e);
        end
        m_shown = e; m_last = 0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int grants = 0;
        int last_c = 0;
        int w;
        logic [15:0] d [2];
        logic [15:0] e;
        d[0] = 16'h0011; d[1] = 16'h0022;
        wait_idle();
        @(negedge clk);
        bus.req0 = 1'b1; bus.data0 = d[0];
        bus.req1 = 1'b1; bus.data1 = d[1];
        w = 1 - m_last;
        for (int c = 1; c <= 60 && grants < 4; c++) begin
            tick();
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
                grants++;
                e = exp_pat(d[w]);
                total++;
                if ({bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_writedata}
                    !== {w == 0, w == 1, 1'b1, 16'h0, e}) begin
                    bad++;
                    $display("FAIL b2b_grant%0d: ack=%b%b cs=%b wd=%h required ack=%b%b cs=1 wd=%h", grants,
                             bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_writedata, w == 0, w == 1, {16'h0, e});
                end
                if (grants > 1) begin
                    total++;
                    if (c - last_c != PERIOD) begin
                        bad++;
                        $display("FAIL b2b_spacing: %0d cycles required %0d", c - last_c, PERIOD);
                    end
                end
                last_c = c; m_shown = e; m_last = w; w = 1 - w;
            end
        end
        total++;
        if (grants != 4) begin
            bad++;
            $display("FAIL b2b_count: grants=%0d required 4", grants);
        end
        @(negedge clk);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
        wait_idle();
    endtask

    task automatic test_skip();
        logic [15:0] e;
        e = exp_pat(16'h1234);
        for (int pass = 0; pass < 2; pass++) begin
            @(negedge clk);
            bus.req1 = 1'b1; bus.data1 = 16'h1234;
            tick();
            total++;
            if ({bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_writedata}
                !== {2'b01, (e != m_shown), 16'h0, e}) begin
                bad++;
                $display("FAIL skip_pass%0d: ack=%b%b cs=%b wd=%h required ack=01 cs=%b wd=%h", pass,
                         bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_writedata, e != m_shown, {16'h0, e});
            end
            m_shown = e; m_last = 1;
            @(negedge clk);
            bus.req1 = 1'b0;
            tick();
            wait_idle();
        end
    endtask

    task automatic test_reset_in_write();
        wait_idle();
        @(negedge clk);
        bus.req0 = 1'b1; bus.data0 = 16'h00C3;
        @(posedge clk);
        #2;
        total++;
        if ({bus.ack0, bus.avm_chipselect} !== 2'b11) begin
            bad++;
            $display("FAIL rst_write_pre: ack0=%b cs=%b required 1 1", bus.ack0, bus.avm_chipselect);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if ({bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata, bus.shown, bus.busy}
            !== {4'b0001, 32'h0, 16'h0, 1'b1}) begin
            bad++;
            $display("FAIL rst_write_async: ack=%b%b cs=%b wn=%b wd=%h shown=%h busy=%b",
                     bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_write_n, bus.avm_writedata, bus.shown, bus.busy);
        end
        bus.req0 = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_last = 1; m_shown = 16'h0;
        tick();
        total++;
        if ({bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_writedata} !== {3'b001, 32'h0000_7F7F}) begin
            bad++;
            $display("FAIL rst_write_reinit: ack=%b%b cs=%b wd=%h required ack=00 cs=1 wd=00007f7f",
                     bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_writedata);
        end
        m_shown = 16'h7F7F;
        wait_idle();
    endtask

    task automatic test_drop_in_hold();
        logic activity = 1'b0;
        wait_idle();
        @(negedge clk);
        bus.req0 = 1'b1; bus.data0 = 16'h0055;
        tick();
        total++;
        if (bus.ack0 !== 1'b1) begin
            bad++;
            $display("FAIL hold_drop_grant: ack0=%b required 1", bus.ack0);
        end
        m_shown = exp_pat(16'h0055); m_last = 0;
        @(negedge clk);
        bus.req0 = 1'b0;
        tick();
        @(negedge clk);
        bus.req1 = 1'b1; bus.data1 = 16'h0066;
        @(negedge clk);
        bus.req1 = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1 || bus.avm_chipselect === 1'b1) activity = 1'b1;
        end
        total++;
        if ({activity, bus.shown} !== {1'b0, m_shown}) begin
            bad++;
            $display("FAIL hold_drop_lost: activity=%b shown=%h required 0 %h", activity, bus.shown, m_shown);
        end
    endtask

    task automatic test_random();
        int w;
        logic [15:0] e;
        pend[0] = 0; pend[1] = 0;
        last_data = 16'h0055;
        for (int it = 0; it < 40; it++) begin
            wait_idle();
            @(negedge clk);
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1;
                    pdat[r] = ($urandom_range(0, 3) == 0) ? last_data : 16'($urandom_range(0, 65535));
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1;
                pdat[0] = 16'($urandom_range(0, 65535));
            end
            bus.req0 = pend[0]; bus.data0 = pdat[0];
            bus.req1 = pend[1]; bus.data1 = pdat[1];
            w = (pend[0] && pend[1]) ? 1 - m_last : (pend[0] ? 0 : 1);
            e = exp_pat(pdat[w]);
            tick();
            total++;
            if ({bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_writedata}
                !== {w == 0, w == 1, (e != m_shown), 16'h0, e}) begin
                bad++;
                $display("FAIL rand_grant it%0d: ack=%b%b cs=%b wd=%h required ack=%b%b cs=%b wd=%h", it,
                         bus.ack0, bus.ack1, bus.avm_chipselect, bus.avm_writedata,
                         w == 0, w == 1, e != m_shown, {16'h0, e});
            end
            m_shown = e; m_last = w; last_data = pdat[w]; pend[w] = 0;
            @(negedge clk);
            bus.req0 = pend[0]; bus.req1 = pend[1];
            for (int k = 1; k <= HOLD_LEN; k++) begin
                tick();
                total++;
                if ({bus.busy, bus.ack0, bus.ack1, bus.avm_chipselect} !== 4'b1000) begin
                    bad++;
                    $display("FAIL rand_hold it%0d k%0d: busy=%b ack=%b%b cs=%b required 1 00 0", it, k,
                             bus.busy, bus.ack0, bus.ack1, bus.avm_chipselect);
                end
            end
            tick();
            total++;
            if ({bus.busy, bus.shown} !== {1'b0, m_shown}) begin
                bad++;
                $display("FAIL rand_idle it%0d: busy=%b shown=%h required 0 %h", it, bus.busy, bus.shown, m_shown);
            end
        end
        @(negedge clk);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_back_to_back();
        test_skip();
        test_reset_in_write();
        test_drop_in_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
